// File: rtl/n_bit_1_to_4_stream_demux.sv
// rtl/n_bit_1_to_4_stream_demux.sv - 1-to-4 valid/ready stream demux with 2-entry buffer per channel
// Optional per-channel pop counters on xfer_cnt when DEMUX_STATS_EN is defined.
module n_bit_1_to_4_stream_demux #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_sel,
    input  logic [N-1:0] in_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [N-1:0] out0_data,
    output logic [N-1:0] out1_data,
    output logic [N-1:0] out2_data,
    output logic [N-1:0] out3_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [63:0]  xfer_cnt
`endif
);

    logic [3:0][1:0]   occ;
    logic [3:0][N-1:0] head;
    logic [3:0][N-1:0] tail;
    logic [3:0]        push;
    logic [3:0]        pop;

    assign in_ready  = (occ[in_sel] != 2'd2) && rst_n;
    assign out0_data = head[0];
    assign out1_data = head[1];
    assign out2_data = head[2];
    assign out3_data = head[3];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (occ[k] != 2'd0);
            pop[k]       = out_valid[k] && out_ready[k];
            push[k]      = in_valid && in_ready && (in_sel == 2'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (occ[k])
                    2'd0: begin
                        if (push[k]) begin
                            head[k] <= in_data;
                            occ[k]  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        // Simultaneous push/pop: the incoming word replaces the departing head.
                        if (push[k] && pop[k]) begin
                            head[k] <= in_data;
                        end else if (push[k]) begin
                            tail[k] <= in_data;
                            occ[k]  <= 2'd2;
                        end else if (pop[k]) begin
                            occ[k]  <= 2'd0;
                        end
                    end
                    2'd2: begin
                        if (pop[k]) begin
                            head[k] <= tail[k];
                            occ[k]  <= 2'd1;
                        end
                    end
                    default: occ[k] <= 2'd0;
                endcase
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [3:0][15:0] cnt;

    assign xfer_cnt = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pop[k]) begin
                    cnt[k] <= cnt[k] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
